// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans a 56-bit active-low 8-digit 7-segment frame onto one segment bus plus 8 digit enables.
// Latency: outputs are registered one cycle after (cnt, idx); the snapshot is taken at cnt==0, idx==0.
// Backpressure: none, free-running scan. Optional per-digit blinking is built only with SEG_BLINK_EN defined.
module seg_scan_driver #(
  parameter int DIV          = 50000,
  parameter int GAP          = 500,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [55:0] seg_in,
  input  logic [7:0]  blink_mask,
  output logic [6:0]  seg_out,
  output logic [7:0]  an,
  output logic        frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_C  = CW'(GAP);
  localparam logic [FW-1:0] BF_M1  = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    BLANK  = 7'h7F;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [55:0]   snap;
  logic          capture;
  logic          in_gap;
  logic          blank_digit;
  logic [6:0]    digit;

  assign capture = (cnt == '0) && (idx == 3'd0);
  assign in_gap  = (cnt < GAP_C);

  always_comb begin
    digit = BLANK;
    for (int k = 0; k < 8; k++) begin
      if (idx == 3'(k)) digit = snap[55-7*k -: 7];
    end
  end

`ifdef SEG_BLINK_EN
  logic [7:0]    mask_q;
  logic [FW-1:0] frame_cnt;
  logic          phase;
  logic          phase_q;

  // Phase is latched with the mask at capture, so a toggle lands on the following frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q    <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      phase_q   <= 1'b0;
    end else if (capture) begin
      mask_q  <= blink_mask;
      phase_q <= phase;
      if (frame_cnt == BF_M1) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  assign blank_digit = phase_q & mask_q[idx];
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, BF_M1};
  assign blank_digit  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 3'd0;
      snap       <= {8{BLANK}};
      seg_out    <= BLANK;
      an         <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      if (cnt == DIV_M1) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      frame_tick <= capture;
      if (capture) snap <= seg_in;

      // The gap at slot start keeps the previous digit's segments from ghosting onto the next anode.
      if (in_gap || blank_digit) begin
        an      <= 8'hFF;
        seg_out <= BLANK;
      end else begin
        an      <= ~(8'h01 << idx);
        seg_out <= digit;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: arithmetic frame model with per-cycle compare plus directed literal checks.
module tb_seg_scan_driver;
  localparam int DIV   = 4;
  localparam int GAP   = 1;
  localparam int BF    = 2;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [55:0] seg_in;
  logic [7:0]  blink_mask;
  logic [6:0]  seg_out;
  logic [7:0]  an;
  logic        frame_tick;
  logic        chk_en = 1'b0;

  int n_pass = 0;
  int n_chk  = 0;

  seg_scan_driver #(.DIV(DIV), .GAP(GAP), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .blink_mask (blink_mask),
    .seg_out    (seg_out),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [55:0] mk_frame(input logic [6:0] base);
    logic [55:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) f[55-7*k -: 7] = base + 7'(k);
    return f;
  endfunction

  // Whether the digit addressed at scan position n is lit, from slot/frame arithmetic alone.
  function automatic logic lit_at(input int n, input logic [7:0] mask);
    int c, i, f;
    c = n % DIV;
    i = (n / DIV) % 8;
    f = n / FRAME;
    if (c < GAP) return 1'b0;
`ifdef SEG_BLINK_EN
    if (((f / BF) % 2) == 1 && mask[i]) return 1'b0;
`else
    if (f < 0 || mask === 8'hxx) return 1'b1;
`endif
    return 1'b1;
  endfunction

  function automatic logic [6:0] digit_of(input logic [55:0] s, input int i);
    return s[55-7*i -: 7];
  endfunction

  int          n_m;
  logic [55:0] m_snap;
  logic [7:0]  m_mask;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_tick;

  always @(posedge clk) begin
    if (rst) begin
      n_m      <= 0;
      m_snap   <= {8{7'h7F}};
      m_mask   <= 8'h00;
      exp_an   <= 8'hFF;
      exp_seg  <= 7'h7F;
      exp_tick <= 1'b0;
    end else begin
      exp_tick <= (n_m % FRAME == 0);
      if (n_m % FRAME == 0) begin
        m_snap <= seg_in;
        m_mask <= blink_mask;
      end
      if (lit_at(n_m, m_mask)) begin
        exp_an  <= ~(8'h01 << ((n_m / DIV) % 8));
        exp_seg <= digit_of(m_snap, (n_m / DIV) % 8);
      end else begin
        exp_an  <= 8'hFF;
        exp_seg <= 7'h7F;
      end
      n_m <= n_m + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("an_model",   32'(an),         32'(exp_an));
      check("seg_model",  32'(seg_out),    32'(exp_seg));
      check("tick_model", 32'(frame_tick), 32'(exp_tick));
      check("one_an_low", 32'($countones(~an) <= 1), 32'd1);
      check("blank_when_off", 32'((an != 8'hFF) || (seg_out == 7'h7F)), 32'd1);
    end
  end

  initial begin
    seg_in = mk_frame(7'h40);
`ifdef SEG_BLINK_EN
    blink_mask = 8'h01;
`else
    blink_mask = 8'hFF;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_an",   32'(an),         32'hFF);
    check("rst_seg",  32'(seg_out),    32'h7F);
    check("rst_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;

    @(negedge clk);
    check("first_tick", 32'(frame_tick), 32'd1);
    check("first_gap",  32'(an),         32'hFF);
    @(negedge clk);
    check("d0_an",  32'(an),      32'hFE);
    check("d0_seg", 32'(seg_out), 32'h40);
    repeat (3) @(negedge clk);
    check("d1_gap_an", 32'(an),         32'hFF);
    check("tick_low",  32'(frame_tick), 32'd0);
    @(negedge clk);
    check("d1_an",  32'(an),      32'hFD);
    check("d1_seg", 32'(seg_out), 32'h41);
    repeat (26) @(negedge clk);
    check("d7_an",  32'(an),      32'h7F);
    check("d7_seg", 32'(seg_out), 32'h47);
    @(negedge clk);
    check("second_tick", 32'(frame_tick), 32'd1);

    repeat (9) @(negedge clk);
    seg_in = mk_frame(7'h10);
    repeat (4) @(negedge clk);
    check("old_d3_an",  32'(an),      32'hF7);
    check("old_d3_seg", 32'(seg_out), 32'h43);
    repeat (24) @(negedge clk);
    check("new_d1_an",  32'(an),      32'hFD);
    check("new_d1_seg", 32'(seg_out), 32'h11);

    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_an",   32'(an),         32'hFF);
    check("midrst_seg",  32'(seg_out),    32'h7F);
    check("midrst_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("restart_tick", 32'(frame_tick), 32'd1);
    @(negedge clk);
    check("restart_an",  32'(an),      32'hFE);
    check("restart_seg", 32'(seg_out), 32'h10);

    repeat (5 * FRAME) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
